// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_ctrl
//  Brief    : Frame-gated game-flow controller: name entry, intro countdown,
//             round timer, pause/resume and finish-to-welcome loop.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module game_flow_ctrl #(
    parameter int NAME_LEN       = 3,
    parameter int START_FRAMES   = 300,
    parameter int GAME_SECONDS   = 180,
    parameter int FRAMES_PER_SEC = 60,
    parameter int NUM_PLAYERS    = 4,
    parameter int TIME_W         = 8
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              frame_tick,
    input  logic [NUM_PLAYERS-1:0]                            left,
    input  logic [NUM_PLAYERS-1:0]                            right,
    input  logic [NUM_PLAYERS-1:0]                            up,
    input  logic [NUM_PLAYERS-1:0]                            down,
    input  logic [NUM_PLAYERS-1:0]                            chop,
    input  logic [NUM_PLAYERS-1:0]                            carry,
    output logic [2:0]                                        game_state,
    output logic [NAME_LEN*8-1:0]                             team_name,
    output logic [((NAME_LEN > 1) ? $clog2(NAME_LEN) : 1)-1:0] name_cursor,
    output logic [TIME_W-1:0]                                 time_left,
    output logic                                              timer_go,
    output logic                                              round_start,
    output logic                                              game_over
);

    localparam int CUR_W   = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
    localparam int SUB_W   = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int START_W = $clog2(START_FRAMES + 1);

    localparam logic [2:0] c_WELCOME = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_PLAY    = 3'd2;
    localparam logic [2:0] c_PAUSE   = 3'd3;
    localparam logic [2:0] c_FINISH  = 3'd4;

    localparam int c_B_LEFT  = 0;
    localparam int c_B_RIGHT = 1;
    localparam int c_B_UP    = 2;
    localparam int c_B_DOWN  = 3;
    localparam int c_B_CHOP  = 4;
    localparam int c_B_PAUSE = 5;

    localparam logic [7:0]         c_LETTER_A   = 8'h41;
    localparam logic [7:0]         c_LETTER_Z   = 8'h5A;
    localparam logic [TIME_W-1:0]  c_GAME_TIME  = TIME_W'(GAME_SECONDS);
    localparam logic [TIME_W-1:0]  c_TIME_ONE   = TIME_W'(1);
    localparam logic [SUB_W-1:0]   c_SUB_LAST   = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [SUB_W-1:0]   c_SUB_ONE    = SUB_W'(1);
    localparam logic [START_W-1:0] c_START_LAST = START_W'(START_FRAMES - 1);
    localparam logic [START_W-1:0] c_START_ONE  = START_W'(1);
    localparam logic [CUR_W-1:0]   c_CUR_LAST   = CUR_W'(NAME_LEN - 1);
    localparam logic [CUR_W-1:0]   c_CUR_ONE    = CUR_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [7:0]         r_letters [NAME_LEN];
    logic [CUR_W-1:0]   r_cursor;
    logic [TIME_W-1:0]  r_time_left;
    logic [SUB_W-1:0]   r_sub_cnt;
    logic [START_W-1:0] r_start_cnt;
    logic               r_round_start;
    logic               r_game_over;
    logic [5:0]         r_prev;
    logic [5:0]         w_any;
    logic [5:0]         w_press;
    logic               w_any_carry;
    logic               w_sub_wrap;
    logic               w_expire;
    logic               w_start_done;
    logic [7:0]         w_letter;

    assign w_any = {|(chop & carry), |chop, |down, |up, |right, |left};
    assign w_press      = w_any & ~r_prev;
    assign w_any_carry  = |carry;
    assign w_sub_wrap   = (r_sub_cnt == c_SUB_LAST);
    assign w_expire     = w_sub_wrap && (r_time_left == c_TIME_ONE);
    assign w_start_done = (r_start_cnt == c_START_LAST);
    assign w_letter     = r_letters[r_cursor];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_WELCOME;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (frame_tick) begin
            case (r_state)
                c_WELCOME: if (w_press[c_B_CHOP]) w_next_state = c_START;
                c_START:   if (w_start_done) w_next_state = c_PLAY;
                c_PLAY: begin
                    if (w_expire)                 w_next_state = c_FINISH;
                    else if (w_press[c_B_PAUSE])  w_next_state = c_PAUSE;
                end
                c_PAUSE:   if (w_press[c_B_CHOP] && !w_any_carry) w_next_state = c_PLAY;
                c_FINISH:  if (w_press[c_B_CHOP]) w_next_state = c_WELCOME;
                default:   w_next_state = c_WELCOME;
            endcase
        end
    end

    always_comb begin
        game_state  = r_state;
        timer_go    = (r_state == c_PLAY);
        round_start = r_round_start;
        game_over   = r_game_over;
        name_cursor = r_cursor;
        time_left   = r_time_left;
    end

    for (genvar g = 0; g < NAME_LEN; g++) begin : g_name
        assign team_name[g*8 +: 8] = r_letters[g];
    end

    // Previous samples reset high so buttons held through reset need a release first.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NAME_LEN; i++) r_letters[i] <= c_LETTER_A;
            r_cursor      <= '0;
            r_time_left   <= c_GAME_TIME;
            r_sub_cnt     <= '0;
            r_start_cnt   <= '0;
            r_round_start <= 1'b0;
            r_game_over   <= 1'b0;
            r_prev        <= '1;
        end else begin
            r_round_start <= 1'b0;
            r_game_over   <= 1'b0;
            if (frame_tick) begin
                r_prev <= w_any;
                case (r_state)
                    c_WELCOME: begin
                        if (w_press[c_B_CHOP]) begin
                            r_start_cnt <= '0;
                        end else if (w_press[c_B_UP]) begin
                            r_letters[r_cursor] <= (w_letter == c_LETTER_A) ? c_LETTER_Z : w_letter - 8'd1;
                        end else if (w_press[c_B_DOWN]) begin
                            r_letters[r_cursor] <= (w_letter == c_LETTER_Z) ? c_LETTER_A : w_letter + 8'd1;
                        end else if (w_press[c_B_RIGHT]) begin
                            if (r_cursor != c_CUR_LAST) r_cursor <= r_cursor + c_CUR_ONE;
                        end else if (w_press[c_B_LEFT]) begin
                            if (r_cursor != '0) r_cursor <= r_cursor - c_CUR_ONE;
                        end
                    end
                    c_START: begin
                        r_start_cnt <= r_start_cnt + c_START_ONE;
                        if (w_start_done) begin
                            r_time_left   <= c_GAME_TIME;
                            r_sub_cnt     <= '0;
                            r_round_start <= 1'b1;
                        end
                    end
                    c_PLAY: begin
                        if (w_sub_wrap) begin
                            r_sub_cnt <= '0;
                            if (r_time_left != '0) r_time_left <= r_time_left - c_TIME_ONE;
                        end else begin
                            r_sub_cnt <= r_sub_cnt + c_SUB_ONE;
                        end
                        if (w_expire) r_game_over <= 1'b1;
                    end
                    c_FINISH: begin
                        if (w_press[c_B_CHOP]) begin
                            r_cursor    <= '0;
                            r_time_left <= c_GAME_TIME;
                        end else begin
                            r_time_left <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_flow_ctrl
//  Brief    : Directed plus randomized bench for game_flow_ctrl against a
//             behavioural model of the game rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam int NL  = 3;
    localparam int SF  = 4;
    localparam int GS  = 3;
    localparam int FPS = 2;
    localparam int NP  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [NP-1:0] b_left = '0, b_right = '0, b_up = '0, b_down = '0, b_chop = '0, b_carry = '0;
    logic [2:0]    game_state;
    logic [NL*8-1:0] team_name;
    logic [1:0]    name_cursor;
    logic [7:0]    time_left;
    logic          timer_go, round_start, game_over;

    int n_checks = 0;
    int n_errors = 0;

    // Model: states 0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
    int m_state, m_cur, m_time, m_sub, m_scnt;
    int m_let [NL];
    bit m_rs, m_go;
    bit p_l, p_r, p_u, p_d, p_c, p_p;

    game_flow_ctrl #(
        .NAME_LEN(NL), .START_FRAMES(SF), .GAME_SECONDS(GS),
        .FRAMES_PER_SEC(FPS), .NUM_PLAYERS(NP), .TIME_W(8)
    ) dut (
        .clock(clk), .reset(rst), .frame_tick(tick),
        .left(b_left), .right(b_right), .up(b_up), .down(b_down),
        .chop(b_chop), .carry(b_carry),
        .game_state(game_state), .team_name(team_name), .name_cursor(name_cursor),
        .time_left(time_left), .timer_go(timer_go),
        .round_start(round_start), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit a_l, a_r, a_u, a_d, a_c, a_p, a_ca;
        bit e_l, e_r, e_u, e_d, e_c, e_p;
        m_rs = 0;
        m_go = 0;
        if (rst) begin
            m_state = 0; m_cur = 0; m_time = GS; m_sub = 0; m_scnt = 0;
            foreach (m_let[i]) m_let[i] = 8'h41;
            {p_l, p_r, p_u, p_d, p_c, p_p} = '1;
            return;
        end
        if (!tick) return;
        a_l = |b_left; a_r = |b_right; a_u = |b_up; a_d = |b_down;
        a_c = |b_chop; a_ca = |b_carry; a_p = |(b_chop & b_carry);
        e_l = a_l & !p_l; e_r = a_r & !p_r; e_u = a_u & !p_u;
        e_d = a_d & !p_d; e_c = a_c & !p_c; e_p = a_p & !p_p;
        case (m_state)
            0: begin
                if (e_c) begin m_state = 1; m_scnt = 0; end
                else if (e_u) m_let[m_cur] = (m_let[m_cur] == "A") ? "Z" : m_let[m_cur] - 1;
                else if (e_d) m_let[m_cur] = (m_let[m_cur] == "Z") ? "A" : m_let[m_cur] + 1;
                else if (e_r) m_cur = (m_cur < NL - 1) ? m_cur + 1 : NL - 1;
                else if (e_l) m_cur = (m_cur > 0) ? m_cur - 1 : 0;
            end
            1: begin
                m_scnt++;
                if (m_scnt == SF) begin m_state = 2; m_time = GS; m_sub = 0; m_rs = 1; end
            end
            2: begin
                m_sub++;
                if (m_sub == FPS) begin
                    m_sub = 0;
                    if (m_time > 0) m_time--;
                    if (m_time == 0) begin m_state = 4; m_go = 1; end
                end
                if (m_state == 2 && e_p) m_state = 3;
            end
            3: if (e_c && !a_ca) m_state = 2;
            4: begin
                m_time = 0;
                if (e_c) begin m_state = 0; m_cur = 0; m_time = GS; end
            end
            default: ;
        endcase
        {p_l, p_r, p_u, p_d, p_c, p_p} = {a_l, a_r, a_u, a_d, a_c, a_p};
    endtask

    task automatic compare_all();
        logic [NL*8-1:0] exp_name;
        for (int i = 0; i < NL; i++) exp_name[i*8 +: 8] = 8'(m_let[i]);
        check_val("game_state", 32'(game_state), 32'(m_state));
        check_val("team_name", 32'(team_name), 32'(exp_name));
        check_val("name_cursor", 32'(name_cursor), 32'(m_cur));
        check_val("time_left", 32'(time_left), 32'(m_time));
        check_val("timer_go", 32'(timer_go), 32'(m_state == 2));
        check_val("round_start", 32'(round_start), 32'(m_rs));
        check_val("game_over", 32'(game_over), 32'(m_go));
    endtask

    task automatic frame(input bit t);
        tick = t;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic btns(input logic [NP-1:0] l, r, u, d, c, ca);
        b_left = l; b_right = r; b_up = u; b_down = d; b_chop = c; b_carry = ca;
    endtask

    task automatic press(input logic [NP-1:0] l, r, u, d, c, ca);
        btns(l, r, u, d, c, ca);
        frame(1);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);
    endtask

    initial begin
        int n;
        // Reset with every button held, then release reset while still held
        btns('1, '1, '1, '1, '1, '0);
        rst = 1;
        frame(1);
        frame(0);
        rst = 0;
        frame(1);
        frame(1);
        check_val("held_through_reset_state", 32'(game_state), 32'd0);
        check_val("held_through_reset_name", 32'(team_name), 32'h414141);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);

        for (int k = 0; k < 3; k++) press('0, '0, '0, 4'b0100, '0, '0);
        check_val("down3_letter0", 32'(team_name[7:0]), 32'h44);
        press('0, 4'b0001, '0, '0, '0, '0);
        press('0, '0, 4'b1000, '0, '0, '0);
        check_val("up_wrap_letter1", 32'(team_name[15:8]), 32'h5A);
        for (int k = 0; k < 5; k++) press('0, 4'b0010, '0, '0, '0, '0);
        check_val("cursor_sat_hi", 32'(name_cursor), 32'd2);
        for (int k = 0; k < 4; k++) press(4'b0001, '0, '0, '0, '0, '0);
        check_val("cursor_sat_lo", 32'(name_cursor), 32'd0);

        // Chop and up together: START wins, letter untouched
        btns('0, '0, 4'b0001, '0, 4'b0001, '0);
        frame(1);
        btns('0, '0, '0, '0, '0, '0);
        check_val("chop_up_start", 32'(game_state), 32'd1);
        check_val("chop_up_letter", 32'(team_name[7:0]), 32'h44);
        frame(0);
        for (int k = 0; k < 3; k++) frame(1);
        check_val("still_start", 32'(game_state), 32'd1);
        frame(1);
        check_val("play_entry", 32'(game_state), 32'd2);
        check_val("round_start_pulse", 32'(round_start), 32'd1);
        frame(0);
        check_val("round_start_drop", 32'(round_start), 32'd0);

        // Pause via chop+carry held ten frames
        btns('0, '0, '0, '0, 4'b0001, 4'b0001);
        for (int k = 0; k < 10; k++) frame(1);
        check_val("paused", 32'(game_state), 32'd3);
        check_val("paused_time", 32'(time_left), 32'd3);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);
        btns('0, '0, '0, '0, 4'b0001, 4'b1000);
        frame(1);
        check_val("chop_with_carry_ignored", 32'(game_state), 32'd3);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);
        press('0, '0, '0, '0, 4'b0001, '0);
        check_val("resumed", 32'(game_state), 32'd2);

        // Pause request on the expiry frame
        n = 0;
        while (!(m_state == 2 && m_time == 1 && m_sub == FPS - 1) && n < 50) begin
            frame(1);
            n++;
        end
        check_val("reach_expiry_bound", 32'(n < 50), 32'd1);
        btns('0, '0, '0, '0, 4'b0100, 4'b0100);
        frame(1);
        check_val("expiry_beats_pause", 32'(game_state), 32'd4);
        check_val("game_over_pulse", 32'(game_over), 32'd1);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);

        // Chop held across FINISH->WELCOME must not start
        btns('0, '0, '0, '0, 4'b0001, '0);
        for (int k = 0; k < 4; k++) frame(1);
        check_val("finish_to_welcome", 32'(game_state), 32'd0);
        check_val("welcome_time_reload", 32'(time_left), 32'd3);
        check_val("name_kept", 32'(team_name), 32'h415A44);
        btns('0, '0, '0, '0, '0, '0);
        frame(1);
        press('0, '0, '0, '0, 4'b0010, '0);

        // Reset mid-round with time_left=1 and the sub-counter part-way
        n = 0;
        while (!(m_state == 2 && m_time == 1 && m_sub == 1) && n < 50) begin
            frame(1);
            n++;
        end
        check_val("reach_mid_bound", 32'(n < 50), 32'd1);
        btns('0, '0, '0, '0, 4'b0001, '0);
        rst = 1;
        frame(0);
        rst = 0;
        check_val("reset_state", 32'(game_state), 32'd0);
        check_val("reset_time", 32'(time_left), 32'd3);
        frame(1);
        frame(1);
        check_val("no_action_after_reset", 32'(game_state), 32'd0);
        btns('0, '0, '0, '0, '0, '0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            logic [NP-1:0] v [6];
            for (int j = 0; j < 6; j++)
                for (int p = 0; p < NP; p++) v[j][p] = ($urandom_range(0, 9) == 0);
            btns(v[0], v[1], v[2], v[3], v[4], v[5]);
            rst = ($urandom_range(0, 499) == 0);
            frame($urandom_range(0, 3) != 0);
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow controller, successor to the fixed 3-letter, single-player game-state FSM.
- Runs on the system clock, gated by a one-cycle frame_tick; no vsync-edge clocking.
- Owns team-name entry (NAME_LEN letters), the intro countdown, an internal round timer, pause/resume, and a finish→welcome loop.
- Merges button inputs from NUM_PLAYERS channels with per-frame edge detection.
- Feeds player_move, orders_and_points and the renderer.

Parameters:
NAME_LEN, 3, number of team-name letters (≥1)
START_FRAMES, 300, frame_ticks spent in START before PLAY (≥1)
GAME_SECONDS, 180, round length in seconds (≥1, < 2^TIME_W)
FRAMES_PER_SEC, 60, frame_ticks per timer second (≥1)
NUM_PLAYERS, 4, number of input channels (≥1)
TIME_W, 8, width of time_left

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per video frame
left, right, up, down, chop, carry  in  NUM_PLAYERS each  per-player button levels, bit i = player i
game_state  out  3  0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
team_name  out  NAME_LEN×8  ASCII letters, team_name[0] leftmost
name_cursor  out  max(1,$clog2(NAME_LEN))  letter index being edited
time_left  out  TIME_W  seconds remaining
timer_go  out  1  high iff game_state==PLAY
round_start  out  1  one-cycle pulse on entry to PLAY from START
game_over  out  1  one-cycle pulse on entry to FINISH

Behaviour:
- One clock, synchronous active-high reset. All state updates only on cycles with frame_tick=1; registered outputs are visible the following cycle. Pulses last exactly one clock cycle.
- Reset values:
  - game_state=WELCOME; all letters 0x41 'A'; name_cursor=0.
  - time_left=GAME_SECONDS; timer_go=0; round_start=0; game_over=0.
  - Start counter and sub-second counter = 0.
  - Previous-button samples = all ones, so buttons held through reset do not fire.
- Input merge: for each button, any = OR over players. press_X = any_X & ~prev_any_X. prev_any_X updates on every frame_tick in every state.
- Pause request: pause_now = OR over players of (chop[i] & carry[i]). press_pause = pause_now & ~prev_pause_now.
- WELCOME: at most one action per frame, priority chop > up > down > right > left.
  - press_chop → START, start counter cleared.
  - press_up: letter at cursor −1; 'A' wraps to 'Z' (0x5A).
  - press_down: letter at cursor +1; 'Z' wraps to 'A'.
  - press_right: cursor+1, saturates at NAME_LEN−1.
  - press_left: cursor−1, saturates at 0.
  - Letters outside 'A'..'Z' never occur.
- START: inputs ignored. Start counter increments per frame_tick. The START_FRAMES-th tick in START → PLAY, which loads time_left=GAME_SECONDS, clears the sub-second counter and fires round_start.
- PLAY, on each frame_tick:
  - Sub-second counter: if it equals FRAMES_PER_SEC−1 → reset to 0 and time_left−1; else +1.
  - If this decrement makes time_left 0 → FINISH, game_over pulses.
  - Else if press_pause → PAUSE.
  - Expiry beats pause on the same frame.
  - time_left never underflows.
- PAUSE: counters frozen and time_left held.
  - press_chop with no player holding carry → PLAY. The sub-second counter resumes from its held value.
  - A chop press while any carry is held is ignored.
- FINISH: time_left=0.
  - press_chop → WELCOME: name_cursor=0, team_name preserved, time_left reloaded to GAME_SECONDS.
  - A chop held across the FINISH→WELCOME transition does not trigger START; a new edge is required.
- Reset mid-operation (any state, any counter value) restores all reset values on that cycle.
- Non-tick cycles: no state, counter or sample changes.

Test Plan:
- Reset, release all, then 3 frames of player 2 down pulses (release between) → team_name[0]=0x44 'D'. One up press from 'A' → 'Z' (0x5A).
- WELCOME: right ×5 with NAME_LEN=3 → name_cursor saturates at 2. Left ×4 → 0. Chop and up pressed on the same frame → START, letter unchanged.
- START_FRAMES=4, FRAMES_PER_SEC=2, GAME_SECONDS=3, chop pressed → PLAY after exactly 4 frame_ticks with a one-cycle round_start. time_left goes 3→2→1→0 every 2 ticks; game_over pulses on the 6th PLAY tick, state=FINISH.
- PLAY: player 0 chop+carry held 10 frames → PAUSE on first frame only, time_left frozen. Release carry, press chop → PLAY with sub-counter unchanged. Chop pressed while player 3 holds carry → stays PAUSE.
- Pause request on the frame time_left hits 0 → FINISH, not PAUSE. Chop held from FINISH into WELCOME → no START until release and re-press. Name preserved.
- Assert reset during PLAY with time_left=1 and sub-counter mid-count → next cycle WELCOME, all outputs at reset values. Button held through reset produces no action.
